seq_det_arbiter: RTL and testbench

Shares one serial pattern-match engine among NCH bit-serial requesters. A round-robin arbiter grants at most one channel per cycle. Per-channel detection context (bit history and fill count) is held in a context table. Each match is reported as a one-cycle pulse tagged with its channel. The block sits between the serial front-end channels and the event/interrupt logic, replacing per-channel detector FSMs.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_engine.sv | 26 ++
 rtl/seq_det_arbiter.sv | 93 +++++++++
 tb/tb_seq_det_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and context type for the multiplexed serial pattern detector.
package seq_det_pkg;

  localparam int NCH = 4;
  localparam int PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PATTERN = 5'b10110;
  localparam int CH_W = $clog2(NCH);

  typedef struct packed {
    logic [PAT_LEN-1:0] hist;
    logic [3:0]         fill;
  } ctx_t;

endpackage

// File: rtl/seq_det_engine.sv
// Combinational next-context / match function shared by all channels.
// SEQ_ARB_OVERLAP_EN selects overlapping detection; otherwise a match wipes the context.
module seq_det_engine
  import seq_det_pkg::*;
#(
  parameter logic [PAT_LEN-1:0] PAT = PATTERN
) (
  input  ctx_t ctx_i,
  input  logic bit_i,
  output ctx_t ctx_o,
  output logic match_o
);

  ctx_t nxt;

  always_comb begin
    nxt.hist = {ctx_i.hist[PAT_LEN-2:0], bit_i};
    nxt.fill = (ctx_i.fill >= 4'(PAT_LEN)) ? 4'(PAT_LEN) : ctx_i.fill + 4'd1;
    match_o  = (nxt.hist == PAT) && (nxt.fill == 4'(PAT_LEN));
    ctx_o    = nxt;
`ifndef SEQ_ARB_OVERLAP_EN
    if (match_o) ctx_o = '0;
`endif
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter feeding one shared pattern engine from NCH bit-serial channels.
// Detection mode follows SEQ_ARB_OVERLAP_EN (see seq_det_engine).
module seq_det_arbiter #(
  parameter int NCH = seq_det_pkg::NCH,
  parameter logic [seq_det_pkg::PAT_LEN-1:0] PATTERN = seq_det_pkg::PATTERN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req_valid,
  input  logic [NCH-1:0]         req_bit,
  output logic [NCH-1:0]         req_ready,
  input  logic [NCH-1:0]         ch_clear,
  output logic                   match_valid,
  output logic [$clog2(NCH)-1:0] match_ch,
  output logic [7:0]             match_cnt
);
  import seq_det_pkg::*;

  localparam int CW = $clog2(NCH);

  logic [CW-1:0]  ptr_q, ptr_d, gnt_idx;
  logic [CW-1:0]  match_ch_q, match_ch_d;
  logic           match_valid_q, match_valid_d;
  logic [7:0]     match_cnt_q, match_cnt_d;
  logic           gnt_any, xfer;
  logic [NCH-1:0] eligible;
  ctx_t           ctx_q [NCH];
  ctx_t           ctx_d [NCH];
  ctx_t           eng_out;
  logic           eng_match;

  // Clear wins over a request on the same channel, so it is simply ineligible.
  always_comb begin
    eligible  = req_valid & ~ch_clear;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_any && eligible[(int'(ptr_q) + k) % NCH]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'((int'(ptr_q) + k) % NCH);
      end
    end
    if (gnt_any && !reset) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer = gnt_any && !reset;

  seq_det_engine #(.PAT(PATTERN)) u_engine (
    .ctx_i   (ctx_q[gnt_idx]),
    .bit_i   (req_bit[gnt_idx]),
    .ctx_o   (eng_out),
    .match_o (eng_match)
  );

  always_comb begin
    for (int i = 0; i < NCH; i++) ctx_d[i] = ch_clear[i] ? '0 : ctx_q[i];
    ptr_d         = ptr_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    match_cnt_d   = match_cnt_q;
    if (xfer) begin
      ctx_d[gnt_idx] = eng_out;
      ptr_d          = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
      if (eng_match) begin
        match_valid_d = 1'b1;
        match_ch_d    = gnt_idx;
        if (match_cnt_q != 8'hFF) match_cnt_d = match_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      match_cnt_q   <= '0;
      for (int i = 0; i < NCH; i++) ctx_q[i] <= '0;
    end else begin
      ptr_q         <= ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
      match_cnt_q   <= match_cnt_d;
      for (int i = 0; i < NCH; i++) ctx_q[i] <= ctx_d[i];
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign match_cnt   = match_cnt_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed and randomized bench for seq_det_arbiter against a queue-based reference model.
module tb_seq_det_arbiter;

  localparam int NCH = 4;
  localparam int PL = 5;
  localparam logic [PL-1:0] PAT = 5'b10110;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_bit, ch_clear, req_ready;
  logic       match_valid;
  logic [1:0] match_ch;
  logic [7:0] match_cnt;

  seq_det_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_bit     (req_bit),
    .req_ready   (req_ready),
    .ch_clear    (ch_clear),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: bits received per channel since its last clear/reset/match.
  bit         mq [NCH][$];
  int         m_ptr;
  logic       exp_mv;
  logic [1:0] exp_mc;
  int         exp_cnt;
  int         sent [NCH];
  int         pulses [NCH];
  int         n_pass, n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic pat_bit(input int i);
    return PAT[PL-1-(i % PL)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    m_ptr = 0; exp_mv = 1'b0; exp_mc = 2'd0; exp_cnt = 0;
  endtask

  task automatic step(input logic rst, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
    int g;
    logic [3:0] exp_rdy;
    logic [PL-1:0] w;
    @(negedge clk);
    reset = rst; req_valid = v; req_bit = b; ch_clear = c;
    #1;
    g = -1;
    if (!rst)
      for (int k = 0; k < NCH; k++) begin
        int i;
        i = (m_ptr + k) % NCH;
        if (g < 0 && v[i] && !c[i]) g = i;
      end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (rst) model_reset();
    else begin
      exp_mv = 1'b0;
      for (int i = 0; i < NCH; i++) if (c[i]) mq[i].delete();
      if (g >= 0) begin
        mq[g].push_back(b[g]);
        sent[g]++;
        m_ptr = (g + 1) % NCH;
        if (mq[g].size() >= PL) begin
          for (int j = 0; j < PL; j++) w[PL-1-j] = mq[g][mq[g].size()-PL+j];
          if (w == PAT) begin
            exp_mv = 1'b1;
            exp_mc = 2'(g);
            if (exp_cnt < 255) exp_cnt++;
`ifndef SEQ_ARB_OVERLAP_EN
            mq[g].delete();
`endif
          end
        end
        if (mq[g].size() > 8) void'(mq[g].pop_front());
      end
    end
    @(posedge clk);
    #1;
    check("match_valid", 32'(match_valid), 32'(exp_mv));
    check("match_ch", 32'(match_ch), 32'(exp_mc));
    check("match_cnt", 32'(match_cnt), 32'(exp_cnt));
    if (match_valid) pulses[match_ch]++;
  endtask

  task automatic feed(input int ch, input logic bv);
    logic [3:0] b;
    b = '0;
    b[ch] = bv;
    step(1'b0, 4'(1 << ch), b, 4'd0);
  endtask

  initial begin
    int cnt0, guard;
    logic [7:0] s8;
    logic [3:0] b4, c4;
    n_pass = 0; n_total = 0;
    for (int i = 0; i < NCH; i++) begin sent[i] = 0; pulses[i] = 0; end
    reset = 1'b1; req_valid = '0; req_bit = '0; ch_clear = '0;
    model_reset();

    // Reset state
    repeat (3) step(1'b1, 4'hF, 4'hF, 4'h0);
    check("reset_cnt", 32'(match_cnt), 32'd0);

    // Single channel 0: 10110
    for (int i = 0; i < PL; i++) feed(0, pat_bit(i));
    check("t1_cnt", 32'(match_cnt), 32'd1);
    step(1'b0, 4'h0, 4'h0, 4'h0);

    // Overlap stream 10110110 on channel 0
    step(1'b0, 4'h0, 4'h0, 4'h1);
    cnt0 = int'(match_cnt);
    s8 = 8'b10110110;
    for (int i = 7; i >= 0; i--) feed(0, s8[i]);
    step(1'b0, 4'h0, 4'h0, 4'h0);
`ifdef SEQ_ARB_OVERLAP_EN
    check("t2_delta", 32'(int'(match_cnt) - cnt0), 32'd2);
`else
    check("t2_delta", 32'(int'(match_cnt) - cnt0), 32'd1);
`endif

    // All channels streaming the pattern in rotation
    step(1'b0, 4'h0, 4'h0, 4'hF);
    for (int i = 0; i < NCH; i++) begin sent[i] = 0; pulses[i] = 0; end
    repeat (20) begin
      for (int i = 0; i < NCH; i++) b4[i] = pat_bit(sent[i]);
      step(1'b0, 4'hF, b4, 4'h0);
    end
    step(1'b0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < NCH; i++) check("t3_pulses", 32'(pulses[i]), 32'd1);

    // Channel 2: 1011, clear while valid, 0, then fresh 10110
    step(1'b0, 4'h0, 4'h0, 4'hF);
    for (int i = 0; i < 4; i++) feed(2, pat_bit(i));
    step(1'b0, 4'h4, 4'h0, 4'h4);
    feed(2, 1'b0);
    for (int i = 0; i < PL; i++) feed(2, pat_bit(i));
    check("t4_ch", 32'(match_ch), 32'd2);
    step(1'b0, 4'h0, 4'h0, 4'h0);

    // Channel 1: 1011, reset, 0
    for (int i = 0; i < 4; i++) feed(1, pat_bit(i));
    step(1'b1, 4'h2, 4'h0, 4'h0);
    feed(1, 1'b0);
    check("t5_cnt", 32'(match_cnt), 32'd0);
    step(1'b0, 4'h0, 4'h0, 4'h0);

    // Saturation on channel 3
    step(1'b0, 4'h0, 4'h0, 4'h8);
    sent[3] = 0; pulses[3] = 0; guard = 0;
    while (pulses[3] < 300 && guard < 2000) begin
      feed(3, pat_bit(sent[3]));
      guard++;
    end
    check("t6_pulses_done", 32'(pulses[3] >= 300), 32'd1);
    check("t6_sat", 32'(match_cnt), 32'd255);

    // Randomized traffic with occasional clears and resets
    repeat (600) begin
      b4 = 4'($urandom);
      c4 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      step(($urandom_range(0, 59) == 0), 4'($urandom), b4, c4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
